// File: rtl/split_result_collector_if.sv
// -----------------------------------------------------------------------------
// split_result_collector_if
//
// Purpose:
//   Beat stream that carries one assignment's worth of split constraint
//   results into the collector.
//
// Handshake:
//   A beat is transferred on a rising clock edge where in_valid and in_ready
//   are both 1. in_x and in_last are only meaningful while in_valid is 1.
//   The master may hold in_valid high for any number of cycles. in_ready
//   comes from a register in the slave and never depends on in_valid, so
//   there is no combinational loop through the handshake.
//
// Signals:
//   in_valid  master -> slave  in_x / in_last carry a beat this cycle
//   in_ready  slave  -> master slave takes a beat this cycle
//   in_x      master -> slave  bit i = x output of split_i for this assignment
//   in_last   master -> slave  this beat is the final assignment of the run
// -----------------------------------------------------------------------------
interface split_result_collector_if #(
   parameter int NUM_SPLITS = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [NUM_SPLITS-1:0] in_x;
   logic                  in_last;

   modport master (
      output in_valid,
      output in_x,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_x,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/split_result_collector.sv
// -----------------------------------------------------------------------------
// split_result_collector
//
// Purpose:
//   Collects the x outputs of NUM_SPLITS split constraints over a run of
//   assignments. A beat whose in_x bits are all 1 is a satisfying assignment;
//   any other beat is unsatisfying. The block counts both kinds, remembers the
//   index of the first satisfying assignment and keeps a sticky mask of the
//   splits that have ever reported 0.
//
//   FSM: IDLE --start--> RUN --accepted beat with in_last--> DONE
//        DONE --start--> RUN (fresh run, results cleared)
//   start is ignored while in RUN. Results hold in IDLE and DONE.
//
// Parameters:
//   NUM_SPLITS  number of split outputs per assignment (width of in_x)
//   CNT_W       width of the counters and of the assignment index
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset, beats start and acceptance
//   start            pulse that begins a collection run (IDLE/DONE only)
//   bus              beat stream (slave side), see split_result_collector_if
//   sat_count        accepted beats with all in_x bits set (saturating)
//   unsat_count      accepted beats with some in_x bit clear (saturating)
//   first_sat_idx    index of the first satisfying beat of the run
//   first_sat_found  first_sat_idx is meaningful
//   fail_mask        bit i sticky-set once any accepted beat had in_x[i]=0
//   busy             state is RUN
//   done             state is DONE
//   fsm_state        encoded FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
//
// Timing:
//   Every output is a register. An accepted beat shows up on the outputs in
//   the cycle after the accepting edge; done rises in the cycle after the
//   last beat is accepted.
// -----------------------------------------------------------------------------
module split_result_collector #(
   parameter int NUM_SPLITS = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   split_result_collector_if.slave bus,
   output logic [CNT_W-1:0]      sat_count,
   output logic [CNT_W-1:0]      unsat_count,
   output logic [CNT_W-1:0]      first_sat_idx,
   output logic                  first_sat_found,
   output logic [NUM_SPLITS-1:0] fail_mask,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             ready_q;
   logic [CNT_W-1:0] idx;
   logic             accept;
   logic             all_set;

   // ready_q is set together with the RUN state, so in_ready is a pure
   // register output and the handshake has no path from in_valid.
   assign bus.in_ready = ready_q;
   assign fsm_state    = state;

   assign accept  = ready_q & bus.in_valid;
   assign all_set = &bus.in_x;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         ready_q         <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         idx             <= '0;
         sat_count       <= '0;
         unsat_count     <= '0;
         first_sat_idx   <= '0;
         first_sat_found <= 1'b0;
         fail_mask       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // Results stay untouched here until a new run starts.
               if (start) begin
                  state           <= RUN;
                  ready_q         <= 1'b1;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  idx             <= '0;
                  sat_count       <= '0;
                  unsat_count     <= '0;
                  first_sat_idx   <= '0;
                  first_sat_found <= 1'b0;
                  fail_mask       <= '0;
               end
            end

            RUN: begin
               if (accept) begin
                  if (all_set) begin
                     if (sat_count != CNT_MAX) begin
                        sat_count <= sat_count + 1'b1;
                     end
                     // Only the first satisfying beat of the run is recorded.
                     if (!first_sat_found) begin
                        first_sat_idx   <= idx;
                        first_sat_found <= 1'b1;
                     end
                  end else begin
                     if (unsat_count != CNT_MAX) begin
                        unsat_count <= unsat_count + 1'b1;
                     end
                     fail_mask <= fail_mask | ~bus.in_x;
                  end

                  // idx saturates like the counters, so on very long runs
                  // first_sat_idx reports CNT_MAX rather than a wrapped value.
                  if (idx != CNT_MAX) begin
                     idx <= idx + 1'b1;
                  end

                  // The last beat is counted above and the run closes on
                  // the same edge.
                  if (bus.in_last) begin
                     state   <= DONE;
                     ready_q <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_split_result_collector.sv
// -----------------------------------------------------------------------------
// tb_split_result_collector
//
// Two collectors share one stimulus stream: dut_a with CNT_W=16 and dut_b
// with CNT_W=4. Both see identical start/rst/beats, so their FSMs move in
// lock-step and only the saturating counters differ. Expected values are
// worked out by hand for each directed step.
// -----------------------------------------------------------------------------
module tb_split_result_collector;

   localparam int NS = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- stimulus signals ----------------
   logic          start;
   logic          in_valid;
   logic          in_last;
   logic [NS-1:0] in_x;

   split_result_collector_if #(.NUM_SPLITS(NS)) bus_a ();
   split_result_collector_if #(.NUM_SPLITS(NS)) bus_b ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_x     = in_x;
   assign bus_a.in_last  = in_last;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_x     = in_x;
   assign bus_b.in_last  = in_last;

   logic [15:0]   a_sat, a_unsat, a_first;
   logic          a_found, a_busy, a_done;
   logic [NS-1:0] a_mask;
   logic [1:0]    a_state;

   logic [3:0]    b_sat, b_unsat, b_first;
   logic          b_found, b_busy, b_done;
   logic [NS-1:0] b_mask;
   logic [1:0]    b_state;

   split_result_collector #(.NUM_SPLITS(NS), .CNT_W(16)) dut_a (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .bus             (bus_a),
      .sat_count       (a_sat),
      .unsat_count     (a_unsat),
      .first_sat_idx   (a_first),
      .first_sat_found (a_found),
      .fail_mask       (a_mask),
      .busy            (a_busy),
      .done            (a_done),
      .fsm_state       (a_state)
   );

   split_result_collector #(.NUM_SPLITS(NS), .CNT_W(4)) dut_b (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .bus             (bus_b),
      .sat_count       (b_sat),
      .unsat_count     (b_unsat),
      .first_sat_idx   (b_first),
      .first_sat_found (b_found),
      .fail_mask       (b_mask),
      .busy            (b_busy),
      .done            (b_done),
      .fsm_state       (b_state)
   );

   // ---------------- bookkeeping ----------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // All inputs change 1 time unit after a rising edge; outputs are sampled
   // at the same point, i.e. away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic send_beat(input logic [NS-1:0] x, input logic last);
      int n;
      in_valid = 1'b1;
      in_x     = x;
      in_last  = last;
      n = 0;
      while (bus_a.in_ready !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      if (n == 16) check("ready_timeout", {31'd0, bus_a.in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_sat"},   a_sat,   0);
      check({tag, "_a_unsat"}, a_unsat, 0);
      check({tag, "_a_first"}, a_first, 0);
      check({tag, "_a_found"}, a_found, 0);
      check({tag, "_a_mask"},  a_mask,  0);
      check({tag, "_a_busy"},  a_busy,  0);
      check({tag, "_a_done"},  a_done,  0);
      check({tag, "_a_ready"}, bus_a.in_ready, 0);
      check({tag, "_a_state"}, a_state, 0);
      check({tag, "_b_sat"},   b_sat,   0);
      check({tag, "_b_unsat"}, b_unsat, 0);
      check({tag, "_b_mask"},  b_mask,  0);
      check({tag, "_b_ready"}, bus_b.in_ready, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_x     = '0;
      in_last  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("reset");

      // Run 1: FF then 07(last), in_valid held across both beats.
      do_start();
      check("r1_start_busy",  a_busy, 1);
      check("r1_start_ready", bus_a.in_ready, 1);
      check("r1_start_state", a_state, 1);
      check("r1_start_done",  a_done, 0);
      send_beat(8'hFF, 1'b0);
      check("r1_b0_sat",   a_sat, 1);
      check("r1_b0_found", a_found, 1);
      check("r1_b0_done",  a_done, 0);
      send_beat(8'h07, 1'b1);
      check("r1_sat",   a_sat, 1);
      check("r1_unsat", a_unsat, 1);
      check("r1_first", a_first, 0);
      check("r1_found", a_found, 1);
      check("r1_mask",  a_mask, 8'hF8);
      check("r1_done",  a_done, 1);
      check("r1_busy",  a_busy, 0);
      check("r1_ready", bus_a.in_ready, 0);
      check("r1_state", a_state, 2);
      // in_valid in DONE has no effect; results hold.
      in_valid = 1'b1;
      in_x     = 8'h00;
      tick();
      tick();
      in_valid = 1'b0;
      check("r1_hold_unsat", a_unsat, 1);
      check("r1_hold_mask",  a_mask, 8'hF8);
      check("r1_hold_done",  a_done, 1);

      // Run 2: restart from DONE clears, then 00, FE, FF, FF(last).
      do_start();
      check("r2_clr_sat",   a_sat, 0);
      check("r2_clr_unsat", a_unsat, 0);
      check("r2_clr_mask",  a_mask, 0);
      check("r2_clr_found", a_found, 0);
      check("r2_clr_done",  a_done, 0);
      check("r2_clr_busy",  a_busy, 1);
      send_beat(8'h00, 1'b0);
      send_beat(8'hFE, 1'b0);
      send_beat(8'hFF, 1'b0);
      send_beat(8'hFF, 1'b1);
      check("r2_sat",     a_sat, 2);
      check("r2_unsat",   a_unsat, 2);
      check("r2_first",   a_first, 2);
      check("r2_found",   a_found, 1);
      check("r2_mask",    a_mask, 8'hFF);
      check("r2_done",    a_done, 1);
      check("r2_b_sat",   b_sat, 2);
      check("r2_b_first", b_first, 2);

      // Run 3: in_valid in IDLE for 5 cycles is ignored.
      do_reset();
      check("r3_rst_state", a_state, 0);
      in_valid = 1'b1;
      in_x     = 8'h00;
      in_last  = 1'b0;
      repeat (5) tick();
      check("r3_idle_unsat", a_unsat, 0);
      check("r3_idle_mask",  a_mask, 0);
      check("r3_idle_state", a_state, 0);
      do_start();
      send_beat(8'hFF, 1'b1);
      check("r3_sat",   a_sat, 1);
      check("r3_unsat", a_unsat, 0);
      check("r3_mask",  a_mask, 0);
      check("r3_done",  a_done, 1);

      // Run 4: start pulsed during RUN is ignored.
      do_start();
      send_beat(8'h00, 1'b0);
      start = 1'b1;
      send_beat(8'hFF, 1'b0);
      start = 1'b0;
      check("r4_mid_unsat", a_unsat, 1);
      check("r4_mid_sat",   a_sat, 1);
      check("r4_mid_busy",  a_busy, 1);
      send_beat(8'hFF, 1'b1);
      check("r4_sat",   a_sat, 2);
      check("r4_unsat", a_unsat, 1);
      check("r4_first", a_first, 1);
      check("r4_mask",  a_mask, 8'hFF);
      check("r4_done",  a_done, 1);

      // Run 5: reset after 3 beats discards the partial run.
      do_start();
      send_beat(8'hFF, 1'b0);
      send_beat(8'h00, 1'b0);
      send_beat(8'hFF, 1'b0);
      check("r5_part_sat",   a_sat, 2);
      check("r5_part_unsat", a_unsat, 1);
      do_reset();
      check_all_zero("r5_rst");
      do_start();
      send_beat(8'h01, 1'b1);
      check("r5_unsat", a_unsat, 1);
      check("r5_mask",  a_mask, 8'hFE);
      check("r5_sat",   a_sat, 0);
      check("r5_found", a_found, 0);
      check("r5_done",  a_done, 1);

      // Run 6: 20 satisfying beats; dut_b saturates at 15.
      do_start();
      for (int i = 0; i < 20; i++) begin
         send_beat(8'hFF, (i == 19));
      end
      check("r6_a_sat",   a_sat, 20);
      check("r6_b_sat",   b_sat, 15);
      check("r6_b_unsat", b_unsat, 0);
      check("r6_b_first", b_first, 0);
      check("r6_b_done",  b_done, 1);
      check("r6_a_done",  a_done, 1);

      // Run 7: 17 unsatisfying beats then one satisfying; idx saturates in dut_b.
      do_start();
      for (int i = 0; i < 17; i++) begin
         send_beat(8'h00, 1'b0);
      end
      send_beat(8'hFF, 1'b1);
      check("r7_a_unsat", a_unsat, 17);
      check("r7_a_sat",   a_sat, 1);
      check("r7_a_first", a_first, 17);
      check("r7_b_unsat", b_unsat, 15);
      check("r7_b_sat",   b_sat, 1);
      check("r7_b_first", b_first, 15);
      check("r7_b_mask",  b_mask, 8'hFF);
      check("r7_b_found", b_found, 1);
      check("r7_b_busy",  b_busy, 0);
      check("r7_b_state", b_state, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/split_result_collector.md
SPLIT_RESULT_COLLECTOR -- requirements
Module: split_result_collector

Interface
REQ-001 The block SHALL have parameter NUM_SPLITS, default 8, giving the number of split constraint outputs consumed per assignment.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of all counters and of the assignment index.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1: pulse that begins a collection run.
REQ-006 Port in_valid, input, 1: in_x and in_last are valid this cycle.
REQ-007 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-008 Port in_x, input, NUM_SPLITS: bit i is the x output of split_i for the current assignment.
REQ-009 Port in_last, input, 1: the current beat is the final assignment of the run.
REQ-010 Port sat_count, output, CNT_W: number of accepted beats with all in_x bits set.
REQ-011 Port unsat_count, output, CNT_W: number of accepted beats with at least one in_x bit clear.
REQ-012 Port first_sat_idx, output, CNT_W: index of the first satisfying beat.
REQ-013 Port first_sat_found, output, 1: first_sat_idx is meaningful.
REQ-014 Port fail_mask, output, NUM_SPLITS: bit i is sticky-set once any accepted beat has in_x[i]=0.
REQ-015 Port busy, output, 1: high in state RUN.
REQ-016 Port done, output, 1: high in state DONE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE: start=1 -> RUN next cycle; all counters, idx, fail_mask and first_sat_found cleared on the same edge.
REQ-019 DONE: start=1 -> RUN with the same clearing as REQ-018; otherwise remain in DONE with results held.
REQ-020 RUN: start SHALL be ignored.
REQ-021 in_ready SHALL equal 1 exactly when state is RUN (registered state, no combinational path from in_valid).
REQ-022 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_valid in any other state SHALL be ignored with no side effect.
REQ-023 Accepted beat with &in_x=1: sat_count increments by 1; if first_sat_found=0, first_sat_idx <= idx and first_sat_found <= 1.
REQ-024 Accepted beat with &in_x=0: unsat_count increments by 1; fail_mask <= fail_mask | ~in_x.
REQ-025 The internal idx SHALL start at 0 and increment by 1 per accepted beat.
REQ-026 sat_count, unsat_count and idx SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-027 Accepted beat with in_last=1: the beat SHALL be counted, and then RUN -> DONE on the same edge.
REQ-028 Outputs SHALL reflect an accepted beat one cycle after acceptance (registered, latency 1); done rises in the cycle after the last beat is accepted.
REQ-029 Results SHALL remain stable in IDLE and DONE until the next start or rst.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and zero every output, in_ready included; rst SHALL take priority over start and over beat acceptance.
REQ-031 rst asserted mid-RUN SHALL discard the partial run; no partial results survive.

Verification
REQ-032 NUM_SPLITS=8. start, then beats in_x=FF, 07 (last) with in_valid held -> sat_count=1, unsat_count=1, first_sat_idx=0, first_sat_found=1, fail_mask=F8, done=1 in the cycle after the second beat is accepted.
REQ-033 NUM_SPLITS=8. start, then beats 00, FE, FF, FF (last) -> sat_count=2, unsat_count=2, first_sat_idx=2, fail_mask=FF.
REQ-034 in_valid=1 while in IDLE for 5 cycles, then start and a single beat FF with in_last=1 -> sat_count=1, unsat_count=0; the IDLE beats are not counted.
REQ-035 CNT_W=4: 20 beats of FF, the last with in_last=1 -> sat_count=15 (saturated), unsat_count=0.
REQ-036 rst asserted after 3 beats mid-RUN -> next cycle state IDLE, all outputs 0; a following start with one beat 01 (last) -> unsat_count=1, fail_mask=FE.
REQ-037 start pulsed during RUN -> counts unaffected; start in DONE -> RUN with counters at 0.
